// File: rtl/pipeline_pkg.sv
// Shared definitions for the 3-stage pipeline: fetch FSM states, reset/bubble
// constants, and the base opcodes that decode also switches on.
package pipeline_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an instruction response that arrives while
// the IF/DE register is occupied and decode is stalled.
module fetch_skid_buffer
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= 32'h0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: program counter, single-outstanding imem requests,
// IF/DE pipeline register with stall back-pressure and execute redirects.
module fetch_stage
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    output logic [1:0]  dbg_state
);

    // Handshakes: a request transfers on a cycle with imem_req && imem_gnt, and
    // imem_addr holds while imem_req waits for gnt. imem_rvalid pulses once per
    // granted request and qualifies imem_rdata. The IF/DE register is taken by
    // decode on any cycle with if_valid_o && !stall_i.

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next, fetch_pc;
    logic         drop, drop_next;
    logic         req_fire, out_free;
    logic         load_mem, load_skid;
    logic         buf_load, buf_clear, buf_valid;
    logic [31:0]  buf_instr, buf_pc;

    assign req_fire  = (state == REQ) && imem_req && imem_gnt;
    assign out_free  = !if_valid_o || !stall_i;
    assign dbg_state = state;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        drop_next  = drop;
        load_mem   = 1'b0;
        load_skid  = 1'b0;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;
        case (state)
            REQ: begin
                if (req_fire) begin
                    state_next = WAIT;
                    pc_next    = pc + 32'd4;
                    // The granted fetch is wrong-path if execute redirects now.
                    if (redirect_i) drop_next = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_next = REQ;
                    drop_next  = 1'b0;
                    if (!drop && !redirect_i) begin
                        if (out_free) begin
                            load_mem = 1'b1;
                        end else begin
                            buf_load   = 1'b1;
                            state_next = HOLD;
                        end
                    end
                end else if (redirect_i) begin
                    drop_next = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    state_next = REQ;
                    buf_clear  = 1'b1;
                end else if (!stall_i && buf_valid) begin
                    state_next = REQ;
                    load_skid  = 1'b1;
                    buf_clear  = 1'b1;
                end
            end
            default: state_next = REQ;
        endcase
        if (redirect_i) pc_next = align_pc(redirect_pc_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= REQ;
            pc         <= RESET_PC;
            fetch_pc   <= RESET_PC;
            drop       <= 1'b0;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            if_valid_o <= 1'b0;
            if_pc_o    <= 32'h0;
            if_instr_o <= NOP_INSTR;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            drop      <= drop_next;
            imem_req  <= (state_next == REQ);
            imem_addr <= pc_next;
            if (req_fire) fetch_pc <= pc;
            if (redirect_i) begin
                if_valid_o <= 1'b0;
                if_instr_o <= NOP_INSTR;
            end else if (load_mem) begin
                if_valid_o <= 1'b1;
                if_pc_o    <= fetch_pc;
                if_instr_o <= imem_rdata;
            end else if (load_skid) begin
                if_valid_o <= 1'b1;
                if_pc_o    <= buf_pc;
                if_instr_o <= buf_instr;
            end else if (if_valid_o && !stall_i) begin
                if_valid_o <= 1'b0;
                if_instr_o <= NOP_INSTR;
            end
        end
    end

    fetch_skid_buffer u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_instr (imem_rdata),
        .load_pc    (fetch_pc),
        .valid      (buf_valid),
        .instr      (buf_instr),
        .pc         (buf_pc)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: randomized memory latency, stalls and redirects
// scored against the expected program-order PC stream.
module tb_fetch_stage;
    import pipeline_pkg::*;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    int consumed = 0;
    int gdel     = 0;
    int rdel     = 0;
    logic prev_redirect = 1'b0;
    logic [31:0] exp_q[$];

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_instr_o    (if_instr_o),
        .dbg_state     (dbg_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Instruction memory contents: distinct word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Program order from base: base, base+4, ... (wrapping at 2^32).
    task automatic sb_reload(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < 1024; i++) exp_q.push_back(base + 32'(i) * 32'd4);
    endtask

    task automatic reset_checks(input string pfx);
        check({pfx, "_req"},   32'(imem_req),   32'd0);
        check({pfx, "_addr"},  imem_addr,       RESET_PC);
        check({pfx, "_valid"}, 32'(if_valid_o), 32'd0);
        check({pfx, "_pc"},    if_pc_o,         32'h0);
        check({pfx, "_instr"}, if_instr_o,      NOP_INSTR);
        check({pfx, "_state"}, 32'(dbg_state),  32'(REQ));
    endtask

    // driver + scoreboard: one cycle of decode-side stimulus
    task automatic tick(input logic s, input logic r, input logic [31:0] t);
        logic [31:0] e;
        @(negedge clk);
        stall_i       = s;
        redirect_i    = r;
        redirect_pc_i = t;
        if (prev_redirect) check("valid_after_redirect", 32'(if_valid_o), 32'd0);
        if (if_valid_o !== 1'b1) check("nop_when_invalid", if_instr_o, NOP_INSTR);
        if (if_valid_o === 1'b1 && !s && !r) begin
            if (exp_q.size() == 0) begin
                check("exp_q_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("if_pc", if_pc_o, e);
                check("if_instr", if_instr_o, mem_word(e));
                consumed++;
            end
        end
        if (r) sb_reload(t & 32'hFFFF_FFFC);
        prev_redirect = r;
    endtask

    task automatic do_reset(input string pfx);
        @(negedge clk);
        rst        = 1'b1;
        stall_i    = 1'b0;
        redirect_i = 1'b0;
        @(negedge clk);
        reset_checks(pfx);
        rst = 1'b0;
        sb_reload(RESET_PC);
        prev_redirect = 1'b0;
    endtask

    // Memory responder: gnt after gdel waiting cycles, rvalid rdel cycles later.
    initial begin : mem_model
        logic        pend, watch, kill;
        int          rcnt, gcnt;
        logic [31:0] paddr, watch_addr;
        pend = 1'b0; watch = 1'b0; kill = 1'b1;
        rcnt = 0; gcnt = 0; paddr = 32'h0; watch_addr = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (watch && !kill) begin
                check("req_held", 32'(imem_req), 32'd1);
                check("addr_stable", imem_addr, watch_addr);
            end
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (imem_req === 1'b1) check("addr_align", 32'(imem_addr[1:0]), 32'd0);
            if (pend) begin
                if (rcnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(paddr);
                    pend        = 1'b0;
                end else begin
                    rcnt--;
                end
            end else if (imem_req === 1'b1) begin
                if (gcnt == 0) begin
                    imem_gnt = 1'b1;
                    pend     = 1'b1;
                    paddr    = imem_addr;
                    rcnt     = rdel;
                    gcnt     = gdel;
                end else begin
                    gcnt--;
                end
            end
            watch      = (imem_req === 1'b1) && !imem_gnt;
            watch_addr = imem_addr;
            kill       = redirect_i || rst;
        end
    end

    initial begin : main
        int          n;
        int          c0;
        logic [31:0] held;
        logic        rd;
        logic [31:0] tg;
        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        @(negedge clk);
        reset_checks("rst_init");
        rst = 1'b0;
        sb_reload(RESET_PC);

        // zero-wait memory: request the cycle after reset, 2 cycles per instruction
        tick(1'b0, 1'b0, 32'h0);
        check("zw_req0", 32'(imem_req), 32'd1);
        check("zw_addr0", imem_addr, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        check("zw_state_wait", 32'(dbg_state), 32'(WAIT));
        check("zw_valid_early", 32'(if_valid_o), 32'd0);
        tick(1'b0, 1'b0, 32'h0);
        check("zw_valid", 32'(if_valid_o), 32'd1);
        check("zw_pc", if_pc_o, 32'h0);
        check("zw_instr", if_instr_o, 32'h0050_0093);
        check("zw_addr4", imem_addr, 32'h4);
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        check("zw_addr8", imem_addr, 32'h8);
        check("zw_req8", 32'(imem_req), 32'd1);
        repeat (10) tick(1'b0, 1'b0, 32'h0);

        // stall while a response arrives -> skid buffer
        n = 0;
        while (dbg_state !== 2'(HOLD) && n < 20) begin tick(1'b1, 1'b0, 32'h0); n++; end
        check("hold_reached", 32'(dbg_state), 32'(HOLD));
        held = if_instr_o;
        repeat (3) begin
            tick(1'b1, 1'b0, 32'h0);
            check("hold_state", 32'(dbg_state), 32'(HOLD));
            check("hold_instr", if_instr_o, held);
            check("hold_valid", 32'(if_valid_o), 32'd1);
        end
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        check("hold_release_valid", 32'(if_valid_o), 32'd1);
        repeat (6) tick(1'b0, 1'b0, 32'h0);

        // redirect while waiting on a slow response
        rdel = 2;
        repeat (4) tick(1'b0, 1'b0, 32'h0);
        n = 0;
        while (dbg_state !== 2'(WAIT) && n < 20) begin tick(1'b0, 1'b0, 32'h0); n++; end
        check("rdw_in_wait", 32'(dbg_state), 32'(WAIT));
        tick(1'b0, 1'b1, 32'h100);
        tick(1'b0, 1'b0, 32'h0);
        check("rdw_drop_wait", 32'(dbg_state), 32'(WAIT));
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin tick(1'b0, 1'b0, 32'h0); n++; end
        check("rdw_req", 32'(imem_req), 32'd1);
        check("rdw_addr", imem_addr, 32'h100);
        repeat (8) tick(1'b0, 1'b0, 32'h0);

        // unaligned redirect coincident with a grant
        rdel = 0;
        repeat (4) tick(1'b0, 1'b0, 32'h0);
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin tick(1'b0, 1'b0, 32'h0); n++; end
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 32'h103);
        check("cg_req_at_redirect", 32'(imem_req), 32'd1);
        tick(1'b0, 1'b0, 32'h0);
        check("cg_drop_wait", 32'(dbg_state), 32'(WAIT));
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin tick(1'b0, 1'b0, 32'h0); n++; end
        check("cg_addr", imem_addr, 32'h100);
        repeat (6) tick(1'b0, 1'b0, 32'h0);

        // slow memory: 3-cycle grant delay, delayed response
        gdel = 3; rdel = 2;
        c0 = consumed;
        repeat (60) tick(1'b0, 1'b0, 32'h0);
        check("slow_progress", 32'(consumed > c0 + 3), 32'd1);

        // reset while a response is in flight
        gdel = 0; rdel = 3;
        repeat (8) tick(1'b0, 1'b0, 32'h0);
        n = 0;
        while (dbg_state !== 2'(WAIT) && n < 20) begin tick(1'b0, 1'b0, 32'h0); n++; end
        check("rst_in_wait", 32'(dbg_state), 32'(WAIT));
        do_reset("rst_mid");
        c0 = consumed;
        repeat (20) tick(1'b0, 1'b0, 32'h0);
        check("rst_progress", 32'(consumed > c0), 32'd1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                gdel = $urandom_range(0, 3);
                rdel = $urandom_range(0, 3);
            end
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rst_rand");
            end else begin
                rd = ($urandom_range(0, 99) < 4);
                tg = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 + 32'($urandom_range(0, 31)))
                                                 : 32'($urandom);
                tick(($urandom_range(0, 9) < 3), rd, tg);
            end
        end

        check("consumed_min", 32'(consumed >= 100), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
